// File: rtl/store_rmw_unit_if.sv
// Store request and data-memory signals shared by the execute stage, the
// store RMW unit and the memory. The unit takes the slave view.
interface store_rmw_unit_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] Addr;
  logic [XLEN-1:0]   StoreData;
  logic [1:0]        StoreType;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [XLEN-1:0]   mem_wdata;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [XLEN-1:0]   mem_rdata;
  logic              done;
  logic              err;

  modport slave (
    input  req_valid, Addr, StoreData, StoreType, mem_gnt, mem_rvalid, mem_rdata,
    output req_ready, mem_req, mem_we, mem_addr, mem_wdata, done, err
  );

  modport master (
    output req_valid, Addr, StoreData, StoreType, mem_gnt, mem_rvalid, mem_rdata,
    input  req_ready, mem_req, mem_we, mem_addr, mem_wdata, done, err
  );
endinterface

// File: rtl/store_rmw_unit.sv
// Byte/half/word store path to a single-port word memory: read-modify-write
// by lane merge, with misaligned stores split across two words.
//
// state | meaning
// IDLE  | ready for a request
// RD0   | read of word 0 requested, waiting for grant
// WAIT0 | waiting for word 0 read data, then merge
// WR0   | write of word 0 requested, waiting for grant
// RD1   | read of word 1 (split stores only)
// WAIT1 | waiting for word 1 read data
// WR1   | write of word 1
// DONE  | done pulse
// ERR   | done + err pulse, nothing written
module store_rmw_unit #(
  parameter int XLEN        = 32,
  parameter int ADDR_W      = 32,
  parameter int MISALIGN_EN = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  store_rmw_unit_if.slave  bus
);
  localparam int BYTES = XLEN / 8;
  localparam int OFFW  = $clog2(BYTES);
  localparam int XW    = $clog2(XLEN);

  typedef enum logic [3:0] {IDLE, RD0, WAIT0, WR0, RD1, WAIT1, WR1, DONE, ERR} state_t;

  state_t            state_q, state_d;
  logic              req_ready_q, req_ready_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] word0_q, word0_d;
  logic [OFFW-1:0]   off_q, off_d;
  logic [OFFW:0]     n_q, n_d;
  logic [XLEN-1:0]   data_q, data_d;
  logic              split_q, split_d;

  logic [OFFW-1:0]   req_off;
  logic [OFFW:0]     req_n;
  logic              req_split;
  logic [ADDR_W-1:0] req_word;
  logic [ADDR_W-1:0] word1;
  logic [XLEN-1:0]   merged;

  function automatic logic [OFFW:0] store_size(input logic [1:0] t);
    logic [OFFW:0] n;
    case (t)
      2'b01:   n = (OFFW+1)'(1);
      2'b10:   n = (OFFW+1)'(2);
      default: n = (OFFW+1)'(BYTES);
    endcase
    return n;
  endfunction

  always_comb begin
    req_off   = bus.Addr[OFFW-1:0];
    req_n     = store_size(bus.StoreType);
    req_split = ({1'b0, req_off} + req_n) > (OFFW+1)'(BYTES);
    req_word  = {bus.Addr[ADDR_W-1:OFFW], {OFFW{1'b0}}};
    word1     = word0_q + ADDR_W'(BYTES);
  end

  // Lane i of the word being merged takes store byte src; on the second word
  // the store bytes continue from where word 0 left off (BYTES - off).
  always_comb begin
    int src;
    logic [XW-1:0] sidx;
    logic [XW-1:0] lidx;
    merged = bus.mem_rdata;
    src    = 0;
    sidx   = '0;
    lidx   = '0;
    for (int i = 0; i < BYTES; i++) begin
      if (state_q == WAIT1) src = i + BYTES - int'(off_q);
      else                  src = i - int'(off_q);
      if (src >= 0 && src < int'(n_q)) begin
        sidx = XW'(8 * src);
        lidx = XW'(8 * i);
        merged[lidx +: 8] = data_q[sidx +: 8];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    req_ready_d = req_ready_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    word0_d     = word0_q;
    off_d       = off_q;
    n_d         = n_q;
    data_d      = data_q;
    split_d     = split_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid && req_ready_q) begin
          word0_d     = req_word;
          off_d       = req_off;
          n_d         = req_n;
          data_d      = bus.StoreData;
          split_d     = req_split;
          req_ready_d = 1'b0;
          if (bus.StoreType == 2'b11 || (req_split && MISALIGN_EN == 0)) begin
            state_d = ERR;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else begin
            mem_req_d  = 1'b1;
            mem_addr_d = req_word;
            if (bus.StoreType == 2'b00 && req_off == '0) begin
              state_d     = WR0;
              mem_we_d    = 1'b1;
              mem_wdata_d = bus.StoreData;
            end else begin
              state_d  = RD0;
              mem_we_d = 1'b0;
            end
          end
        end
      end
      RD0, RD1: begin
        if (bus.mem_gnt) begin
          state_d   = (state_q == RD0) ? WAIT0 : WAIT1;
          mem_req_d = 1'b0;
        end
      end
      WAIT0, WAIT1: begin
        if (bus.mem_rvalid) begin
          state_d     = (state_q == WAIT0) ? WR0 : WR1;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_wdata_d = merged;
        end
      end
      WR0: begin
        if (bus.mem_gnt) begin
          if (split_q) begin
            state_d    = RD1;
            mem_we_d   = 1'b0;
            mem_addr_d = word1;
          end else begin
            state_d   = DONE;
            mem_req_d = 1'b0;
            mem_we_d  = 1'b0;
            done_d    = 1'b1;
          end
        end
      end
      WR1: begin
        if (bus.mem_gnt) begin
          state_d   = DONE;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          done_d    = 1'b1;
        end
      end
      DONE, ERR: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
      end
      default: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
        mem_req_d   = 1'b0;
        mem_we_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b1;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      word0_q     <= '0;
      off_q       <= '0;
      n_q         <= '0;
      data_q      <= '0;
      split_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      done_q      <= done_d;
      err_q       <= err_d;
      word0_q     <= word0_d;
      off_q       <= off_d;
      n_q         <= n_d;
      data_q      <= data_d;
      split_q     <= split_d;
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
endmodule

// File: doc/store_rmw_unit.md
Name: store_rmw_unit

Overview:
- Sequential, parametrised store path that sits between the execute stage and a single-port word-wide data memory.
- Accepts one store request at a time: byte, half or full-word, aligned or misaligned.
- Performs read-modify-write by lane merge and writes back one word, or two words when the store straddles a word boundary.
- Signals completion, or an error, with a one-cycle done pulse.

Parameters:
- XLEN, 32, data/word width in bits; must be 32 or 64; BYTES = XLEN/8, OFFW = log2(BYTES).
- ADDR_W, 32, byte-address width.
- MISALIGN_EN, 1, 1 = split misaligned stores into two words; 0 = flag them as errors.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  1  store request valid.
- req_ready  out  1  unit idle and able to accept a request.
- Addr  in  ADDR_W  byte address of the store.
- StoreData  in  XLEN  store source register value; data is taken from its low bytes.
- StoreType  in  2  00 = full word, 01 = byte, 10 = half, 11 = reserved.
- mem_req  out  1  memory access request.
- mem_we  out  1  1 = write, 0 = read; valid while mem_req=1.
- mem_addr  out  ADDR_W  word-aligned address (low OFFW bits always 0).
- mem_wdata  out  XLEN  merged write word.
- mem_gnt  in  1  memory accepts the current request this cycle.
- mem_rvalid  in  1  read data valid; arrives at least 1 cycle after gnt.
- mem_rdata  in  XLEN  read data.
- done  out  1  one-cycle completion pulse.
- err  out  1  qualifies done: 1 = request rejected, no memory write occurred.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE.
  - req_ready=1; mem_req, mem_we, done, err = 0; mem_addr and mem_wdata = 0.
  - Any in-flight access is abandoned immediately.
  - A mem_rvalid arriving after reset is ignored.
- Size and offset: n = 1/2/BYTES bytes for StoreType 01/10/00. o = Addr[OFFW-1:0]. Store is split when o+n > BYTES.
- Accept: in IDLE, req_valid & req_ready latches Addr, StoreData and StoreType. req_ready=0 in every state other than IDLE.
- Error path: StoreType=11, or a split store with MISALIGN_EN=0 -> ERR for one cycle: done=1, err=1, no mem_req -> IDLE.
- Full-word aligned store (StoreType=00, o=0): IDLE -> WR0 directly, with no read.
- FSM for all other valid stores, IDLE -> RD0 -> WAIT0 -> WR0 -> [RD1 -> WAIT1 -> WR1] -> DONE -> IDLE:
  - RD0: mem_req=1, mem_we=0, mem_addr = Addr with low OFFW bits cleared. Hold until mem_gnt, then go to WAIT0.
  - WAIT0: mem_req=0. On mem_rvalid, merge: lanes o..min(o+n,BYTES)-1 take StoreData bytes 0.., other lanes keep mem_rdata -> WR0.
  - WR0: mem_req=1, mem_we=1, mem_wdata = merged word. On mem_gnt go to RD1 if split, else DONE.
  - RD1/WAIT1/WR1: same as RD0/WAIT0/WR0, with mem_addr = word0 + BYTES (mod 2^ADDR_W). Lanes 0..(o+n-BYTES-1) take the remaining StoreData bytes.
  - DONE: done=1, err=0 for one cycle -> IDLE.
- Handshake rules:
  - mem_req, mem_we, mem_addr and mem_wdata are registered and stay stable until the cycle mem_gnt=1.
  - Gnt in the same cycle mem_req rises is legal, giving minimum latency.
  - mem_rvalid outside WAIT0/WAIT1 is ignored.
- Latency with gnt and rvalid immediate:
  - Aligned full word: accept -> done in 2 cycles (WR0, DONE).
  - Unsplit RMW: 4 cycles.
  - Split: 7 cycles.
  - Error: 1 cycle.
- Address wrap: a split at the top word (e.g. Addr=0xFFFFFFFF, half) sends its second access to word 0x00000000.
- No back-to-back: the next request is accepted at the earliest in the cycle after DONE/ERR, when IDLE has req_ready=1.
- Reset mid-operation (e.g. between WR0 and WR1) leaves word1 unwritten. No done pulse is produced for the abandoned request.

Test Plan:
- Byte store, XLEN=32: Addr=0x102, StoreData=0x000000AB, rdata=0x11223344 -> read 0x100, write 0x100 data 0x11AB3344, done=1 err=0 after 4 cycles.
- Half store: Addr=0x202, StoreData=0x0000BEEF, rdata=0xCAFEF00D -> write 0x200 data 0xBEEFF00D.
- Aligned word: Addr=0x300, StoreData=0xDEADBEEF -> no read; single write 0x300 0xDEADBEEF; done 2 cycles after accept.
- Split word, MISALIGN_EN=1: Addr=0x403, StoreData=0xA1B2C3D4, rdata 0x11111111 then 0x22222222 -> writes 0x400 0xD4111111, then 0x404 0x22A1B2C3; done after 7 cycles. Same request with MISALIGN_EN=0 -> done=1 err=1, mem_req never asserted.
- StoreType=11 -> err pulse. Stall case: mem_gnt held low 5 cycles in WR0 -> mem_addr/mem_wdata stable throughout, and one write occurs on grant.
- reset_n pulsed low in WAIT1 -> mem_req=0 and req_ready=1 immediately; no done; a late mem_rvalid causes no write.
